pipe_stage_hsreg: RTL and testbench

//  Parametrised inter-stage pipeline register: successor to the fixed EX/MEM-style dff stage.

---
 rtl/pipe_stage_hsreg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_hsreg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hsreg.sv
// ============================================================================
// Module   : pipe_stage_hsreg
// Brief    : Inter-stage pipeline register with valid/ready handshake,
//            optional 2-entry skid buffer, flush and bubble control masking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_hsreg #(
    parameter int CTRL_W = 3,
    parameter int RN_W   = 5,
    parameter int DATA_W = 64,
    parameter int SKID   = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [RN_W-1:0]   in_rn_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [RN_W-1:0]   out_rn_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    localparam int BW = CTRL_W + RN_W + DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   main_q, main_d, skid_q;
    logic [BW-1:0]   in_beat;
    logic            main_load, skid_load;
    logic            push, pop, out_valid;

    assign in_beat   = {in_ctrl_i, in_rn_i, in_data_i};
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid_i & in_ready_o;
    assign pop       = out_valid & out_ready_i;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d   = ST_ONE;
                    main_d    = in_beat;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d    = in_beat;
                    main_load = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end else if (push) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d   = ST_ONE;
                    main_d    = skid_q;
                    main_load = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards every held beat and any beat offered this cycle;
        // payload registers keep their contents, only validity is cleared.
        if (flush_i) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            if (main_load) begin
                main_q <= main_d;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            // Ready is precomputed from the next state so that out_ready never
            // reaches in_ready combinationally; gated by reset while it is held.
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    rdy_q  <= 1'b1;
                    skid_q <= '0;
                end else begin
                    rdy_q <= (state_d != ST_FULL);
                    if (skid_load) begin
                        skid_q <= in_beat;
                    end
                end
            end

            assign in_ready_o = rdy_q & ~reset_i;
        end else begin : g_noskid
            assign skid_q     = '0;
            assign in_ready_o = ~reset_i & (~out_valid | out_ready_i);
        end
    endgenerate

    assign out_valid_o = out_valid;
    assign out_ctrl_o  = main_q[BW-1 -: CTRL_W] & {CTRL_W{out_valid}};
    assign out_rn_o    = main_q[DATA_W +: RN_W];
    assign out_data_o  = main_q[DATA_W-1:0];
    assign occupancy_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_hsreg.sv
// ============================================================================
// Module   : tb_pipe_stage_hsreg
// Brief    : Self-checking bench for pipe_stage_hsreg (SKID=1 and SKID=0 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_hsreg;

    localparam int CW = 3;
    localparam int RW = 5;
    localparam int DW = 64;
    localparam int BW = CW + RW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fl1, iv1, ir1, ov1, or1;
    logic [CW-1:0] ic1, oc1;
    logic [RW-1:0] irn1, orn1;
    logic [DW-1:0] id1, od1;
    logic [1:0]    occ1;

    logic          fl0, iv0, ir0, ov0, or0;
    logic [CW-1:0] ic0, oc0;
    logic [RW-1:0] irn0, orn0;
    logic [DW-1:0] id0, od0;
    logic [1:0]    occ0;

    pipe_stage_hsreg #(.CTRL_W(CW), .RN_W(RW), .DATA_W(DW), .SKID(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .flush_i(fl1),
        .in_valid_i(iv1), .in_ready_o(ir1), .in_ctrl_i(ic1), .in_rn_i(irn1), .in_data_i(id1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_ctrl_o(oc1), .out_rn_o(orn1),
        .out_data_o(od1), .occupancy_o(occ1)
    );

    pipe_stage_hsreg #(.CTRL_W(CW), .RN_W(RW), .DATA_W(DW), .SKID(0)) dut0 (
        .clock_i(clk), .reset_i(rst), .flush_i(fl0),
        .in_valid_i(iv0), .in_ready_o(ir0), .in_ctrl_i(ic0), .in_rn_i(irn0), .in_data_i(id0),
        .out_valid_o(ov0), .out_ready_i(or0), .out_ctrl_o(oc0), .out_rn_o(orn0),
        .out_data_o(od0), .occupancy_o(occ0)
    );

    int checks = 0;
    int passed = 0;

    logic [BW-1:0] q1[$];
    logic [BW-1:0] q0[$];

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [CW-1:0] ctrl;
        logic [RW-1:0] rn;
        logic [DW-1:0] data;
        logic          e_ir;
        logic          e_ov;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [CW-1:0] ctrl, input logic [RW-1:0] rn,
                                input logic [DW-1:0] data, input logic e_ir,
                                input logic e_ov, input logic [1:0] e_occ);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl; v.rn = rn; v.data = data;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ;
        return v;
    endfunction

    // Scoreboard step for the SKID=1 build, called once per cycle at negedge.
    task automatic sb1();
        chk("occ1_vs_model", 128'(occ1), 128'(q1.size()));
        if (ov1) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL sb1_extra_beat: got %0h expected none", {oc1, orn1, od1});
            end else begin
                chk("sb1_beat", 128'({oc1, orn1, od1}), 128'(q1[0]));
                if (or1) void'(q1.pop_front());
            end
        end else begin
            chk("sb1_bubble_ctrl", 128'(oc1), 128'(0));
        end
        if (fl1) q1.delete();
        else if (iv1 && ir1) q1.push_back({ic1, irn1, id1});
    endtask

    task automatic sb0();
        chk("occ0_vs_model", 128'(occ0), 128'(q0.size()));
        if (ov0) begin
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL sb0_extra_beat: got %0h expected none", {oc0, orn0, od0});
            end else begin
                chk("sb0_beat", 128'({oc0, orn0, od0}), 128'(q0[0]));
                if (or0) void'(q0.pop_front());
            end
        end else begin
            chk("sb0_bubble_ctrl", 128'(oc0), 128'(0));
        end
        if (fl0) q0.delete();
        else if (iv0 && ir0) q0.push_back({ic0, irn0, id0});
    endtask

    task automatic step();
        @(negedge clk);
        sb1();
        sb0();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fl1 = 1'b0; iv1 = 1'b1; or1 = 1'b0; ic1 = 3'b111; irn1 = 5'd3; id1 = 64'h55;
        fl0 = 1'b0; iv0 = 1'b1; or0 = 1'b0; ic0 = 3'b111; irn0 = 5'd3; id0 = 64'h55;

        // Reset held two edges with in_valid asserted
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready1", 128'(ir1), 128'(0));
        chk("rst_out_valid1", 128'(ov1), 128'(0));
        chk("rst_out_ctrl1", 128'(oc1), 128'(0));
        chk("rst_in_ready0", 128'(ir0), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        iv1 = 1'b0; iv0 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready1", 128'(ir1), 128'(1));
        chk("post_rst_occ1", 128'(occ1), 128'(0));
        chk("post_rst_rn1", 128'(orn1), 128'(0));
        chk("post_rst_data1", 128'(od1), 128'(0));
        chk("post_rst_in_ready0", 128'(ir0), 128'(1));
        @(posedge clk); #1;

        // Streaming: rn=1..8 back to back with out_ready high
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 3'(i), 5'(i), 64'(i * 'h11),
                             1'b1, (i > 1), (i > 1) ? 2'd1 : 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0));
        // Stall: A, B into a blocked stage, offered beat X refused while full
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd1, 5'd20, 64'hAAAA, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd2, 5'd21, 64'hBBBB, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd3, 5'd22, 64'hDEAD, 1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0));
        // Flush at FULL with beat C offered, then flush dropping an accepted push F
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd4, 5'd9,  64'hD0, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd5, 5'd10, 64'hE0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 3'd6, 5'd11, 64'hC0, 1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 3'd7, 5'd12, 64'hF0, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0));
        // Bubble mask: all-ones control accepted, then popped with nothing behind it
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 3'b111, 5'd7, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1, 1'b0, 2'd0));

        for (int r = 0; r < tbl.size(); r++) begin
            iv1 = tbl[r].iv; or1 = tbl[r].ordy; fl1 = tbl[r].fl;
            ic1 = tbl[r].ctrl; irn1 = tbl[r].rn; id1 = tbl[r].data;
            @(negedge clk);
            chk($sformatf("row%0d_in_ready", r), 128'(ir1), 128'(tbl[r].e_ir));
            chk($sformatf("row%0d_out_valid", r), 128'(ov1), 128'(tbl[r].e_ov));
            chk($sformatf("row%0d_occupancy", r), 128'(occ1), 128'(tbl[r].e_occ));
            sb1();
            sb0();
            @(posedge clk); #1;
        end
        fl1 = 1'b0;

        @(negedge clk);
        chk("bubble_out_valid", 128'(ov1), 128'(0));
        chk("bubble_out_ctrl", 128'(oc1), 128'(0));
        chk("bubble_rn_held", 128'(orn1), 128'(7));
        chk("bubble_data_held", 128'(od1), 128'(64'h1234_5678_9ABC_DEF0));
        @(posedge clk); #1;

        // Random traffic on both builds against the queue models
        for (int c = 0; c < 200; c++) begin
            iv1 = 1'($urandom); or1 = 1'($urandom);
            ic1 = 3'($urandom); irn1 = 5'($urandom); id1 = {$urandom, $urandom};
            iv0 = 1'($urandom); or0 = 1'($urandom);
            ic0 = 3'($urandom); irn0 = 5'($urandom); id0 = {$urandom, $urandom};
            @(negedge clk);
            chk("rand_ir1_vs_full", 128'(ir1), 128'(occ1 != 2'd2));
            chk("rand_ir0_follow", 128'(ir0), 128'(!ov0 || or0));
            chk("rand_occ0_max1", 128'(occ0), 128'({1'b0, ov0}));
            sb1();
            sb0();
            @(posedge clk); #1;
        end

        iv1 = 1'b0; or1 = 1'b1; iv0 = 1'b0; or0 = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("drain_q1_empty", 128'(q1.size()), 128'(0));
        chk("drain_q0_empty", 128'(q0.size()), 128'(0));
        chk("drain_occ1", 128'(occ1), 128'(0));
        chk("drain_occ0", 128'(occ0), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
